// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 channel selector: GROUP:1 leaf muxes, then a group select, each registered.
// Optional auto-scan select source is built only when MUX_TREE_AUTO_SCAN_EN is defined.
module mux_tree_pipe #(
    parameter int unsigned N_IN   = 16,
    parameter int unsigned DATA_W = 1,
    parameter int unsigned GROUP  = 8,
    parameter int unsigned SEL_W  = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN*DATA_W-1:0] in,
    input  logic [SEL_W-1:0]       select,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   scan_mode,
    output logic [DATA_W-1:0]      out,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_err,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned GSEL_W = $clog2(GROUP);
    localparam int unsigned NG     = (N_IN + GROUP - 1) / GROUP;
    localparam int unsigned HI_W   = (SEL_W > GSEL_W) ? (SEL_W - GSEL_W) : 1;
    localparam int unsigned PAD_W  = NG * GROUP * DATA_W;
    localparam logic [SEL_W:0] N_IN_EXT = (SEL_W + 1)'(N_IN);

    // Handshake: each stage loads when it is empty or its consumer is draining it.
    logic s1_valid_q;
    logic s2_load;
    logic s1_load;
    logic accept;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && in_ready;

    // Select source for the beat being accepted.
    logic [SEL_W-1:0] eff_sel;
    logic             eff_err;
    logic             sel_oob;

    assign sel_oob = {1'b0, select} >= N_IN_EXT;

`ifdef MUX_TREE_AUTO_SCAN_EN
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_IN - 1);

    logic [SEL_W-1:0] scan_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_ptr_q <= '0;
        end else if (accept && scan_mode) begin
            scan_ptr_q <= (scan_ptr_q == LAST_CH) ? '0 : scan_ptr_q + 1'b1;
        end
    end

    // Scanned beats always address a real channel, so they never flag an error.
    assign eff_sel = scan_mode ? scan_ptr_q : select;
    assign eff_err = scan_mode ? 1'b0 : sel_oob;
`else
    logic unused_scan_mode;

    assign unused_scan_mode = scan_mode;
    assign eff_sel          = select;
    assign eff_err          = sel_oob;
`endif

    // Leaf stage: zero padding makes channels beyond N_IN read as 0.
    logic [PAD_W-1:0]  in_pad;
    logic [GSEL_W-1:0] sel_lo;
    logic [HI_W-1:0]   sel_hi;
    logic [DATA_W-1:0] grp_d [NG];

    assign in_pad = PAD_W'(in);
    assign sel_lo = GSEL_W'(eff_sel);
    assign sel_hi = HI_W'(eff_sel >> GSEL_W);

    always_comb begin
        for (int unsigned g = 0; g < NG; g++) begin
            grp_d[g] = in_pad[(g * GROUP + 32'(sel_lo)) * DATA_W +: DATA_W];
        end
    end

    logic [DATA_W-1:0] grp_q [NG];
    logic [SEL_W-1:0]  s1_sel_q;
    logic [HI_W-1:0]   s1_hi_q;
    logic              s1_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= '0;
            s1_hi_q    <= '0;
            s1_err_q   <= 1'b0;
            for (int unsigned g = 0; g < NG; g++) begin
                grp_q[g] <= '0;
            end
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sel_q <= eff_sel;
                s1_hi_q  <= sel_hi;
                s1_err_q <= eff_err;
                for (int unsigned g = 0; g < NG; g++) begin
                    grp_q[g] <= grp_d[g];
                end
            end
        end
    end

    // Group-select stage; an out-of-range high index matches no group and yields 0.
    logic [DATA_W-1:0] s2_data;

    always_comb begin
        s2_data = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            if (32'(s1_hi_q) == g) begin
                s2_data = grp_q[g];
            end
        end
        if (s1_err_q) begin
            s2_data = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out     <= s2_data;
                out_sel <= s1_sel_q;
                out_err <= s1_err_q;
            end
        end
    end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: four instances with different N_IN/GROUP/DATA_W,
// expectations pushed on accept from a channel-array model, popped by the output monitor.
module tb_mux_tree_pipe;

    localparam int NL = 4;

    function automatic int unsigned lane_n(int l);
        case (l)
            0:       return 16;
            1:       return 12;
            2:       return 4;
            default: return 12;
        endcase
    endfunction

    function automatic int unsigned lane_g(int l);
        return (l == 3) ? 4 : 8;
    endfunction

    function automatic int unsigned lane_dw(int l);
        return (l == 2) ? 3 : 8;
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NL-1:0] valid_v, in_ready_v, scan_v, out_err_v, out_valid_v, out_ready_v;
    logic [3:0]    sel_v     [NL];
    logic [7:0]    out_v     [NL];
    logic [3:0]    out_sel_v [NL];
    logic [7:0]    chan      [NL][16];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < NL; i++) begin : g_lane
        localparam int unsigned N  = lane_n(i);
        localparam int unsigned DW = lane_dw(i);
        localparam int unsigned G  = lane_g(i);
        localparam int unsigned SW = $clog2(N);

        logic [N*DW-1:0] in_l;
        logic [DW-1:0]   out_l;
        logic [SW-1:0]   out_sel_l;

        for (genvar k = 0; k < N; k++) begin : g_ch
            assign in_l[k*DW +: DW] = chan[i][k][DW-1:0];
        end

        mux_tree_pipe #(
            .N_IN   (N),
            .DATA_W (DW),
            .GROUP  (G)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in        (in_l),
            .select    (sel_v[i][SW-1:0]),
            .in_valid  (valid_v[i]),
            .in_ready  (in_ready_v[i]),
            .scan_mode (scan_v[i]),
            .out       (out_l),
            .out_sel   (out_sel_l),
            .out_err   (out_err_v[i]),
            .out_valid (out_valid_v[i]),
            .out_ready (out_ready_v[i])
        );

        assign out_v[i]     = 8'(out_l);
        assign out_sel_v[i] = 4'(out_sel_l);
    end

    typedef struct {
        logic [7:0] data;
        logic [3:0] sel;
        logic       err;
        int         cyc;
    } beat_t;

    beat_t exp_q [NL][$];
    int    scan_ptr [NL];
    int    pop_log [$];
    int    checks = 0;
    int    errors = 0;
    bit    lat_chk = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output side pops and compares; input side builds the expected beat from the channel array.
    task automatic mon_step();
        beat_t b;
        int    s;
        int    n;
        if (rst) begin
            for (int l = 0; l < NL; l++) begin
                exp_q[l].delete();
                scan_ptr[l] = 0;
            end
            return;
        end
        for (int l = 0; l < NL; l++) begin
            if (out_valid_v[l]) begin
                checks++;
                if (exp_q[l].size() == 0) begin
                    errors++;
                    $display("FAIL spurious_beat lane%0d got data=%0h sel=%0d expected no beat",
                             l, out_v[l], out_sel_v[l]);
                end else begin
                    b = exp_q[l][0];
                    if (out_v[l] !== b.data || out_sel_v[l] !== b.sel || out_err_v[l] !== b.err) begin
                        errors++;
                        $display("FAIL beat lane%0d got data=%0h sel=%0d err=%0b expected data=%0h sel=%0d err=%0b",
                                 l, out_v[l], out_sel_v[l], out_err_v[l], b.data, b.sel, b.err);
                    end
                    if (out_ready_v[l]) begin
                        void'(exp_q[l].pop_front());
                        if (l == 0) pop_log.push_back(int'(out_sel_v[0]));
                        if (lat_chk) chk("latency", cyc - b.cyc, 2);
                    end
                end
            end
            if (valid_v[l] && in_ready_v[l]) begin
                n = lane_n(l);
                s = int'(sel_v[l]);
                if (n == 4) s = s & 3;
`ifdef MUX_TREE_AUTO_SCAN_EN
                if (scan_v[l]) begin
                    s = scan_ptr[l];
                    scan_ptr[l] = (scan_ptr[l] + 1) % n;
                    b.err = 1'b0;
                end else
`endif
                b.err = (s >= n);
                b.sel  = 4'(s);
                b.data = b.err ? 8'h00 : (chan[l][s] & 8'((1 << lane_dw(l)) - 1));
                b.cyc  = cyc;
                exp_q[l].push_back(b);
            end
        end
    endtask

    task automatic send(int l, int s);
        int n = 0;
        valid_v[l] = 1'b1;
        sel_v[l]   = 4'(s);
        while (1) begin
            @(negedge clk);
            if (in_ready_v[l]) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout lane%0d got in_ready=0 expected 1 within 50 clks", l);
        end
        @(posedge clk);
        #1;
        valid_v[l] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        int pend;
        valid_v     = '0;
        out_ready_v = '1;
        while (n < 200) begin
            pend = 0;
            for (int l = 0; l < NL; l++) pend += exp_q[l].size();
            if (pend == 0 && out_valid_v == '0) break;
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", (n >= 200), 0);
    endtask

    initial begin
        int c0;
        int seen;
        rst         = 1'b1;
        valid_v     = '0;
        scan_v      = '0;
        out_ready_v = '1;
        for (int l = 0; l < NL; l++) begin
            sel_v[l]    = '0;
            scan_ptr[l] = 0;
            for (int k = 0; k < 16; k++) chan[l][k] = 8'($urandom);
        end
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            begin
                // Reset state
                @(posedge clk);
                #1;
                chk("in_ready_in_reset", in_ready_v, 4'hF);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                #1;
                chk("rst_out_valid", out_valid_v, 0);
                chk("rst_out", out_v[0], 0);
                chk("rst_out_sel", out_sel_v[0], 0);
                chk("rst_out_err", out_err_v, 0);
                chk("rst_in_ready", in_ready_v, 4'hF);

                // Sweep 16 channels back-to-back, then the small tree
                for (int k = 0; k < 16; k++) chan[0][k] = 8'(8'hA0 + k);
                @(posedge clk);
                #1;
                lat_chk = 1'b1;
                c0 = cyc;
                for (int k = 0; k < 16; k++) send(0, k);
                chk("sweep_one_per_clk", cyc - c0, 16);
                drain();
                for (int k = 0; k < 4; k++) send(2, k);
                drain();
                lat_chk = 1'b0;

                // Backpressure: two beats buffer, third stalls
                out_ready_v[0] = 1'b0;
                send(0, 3);
                send(0, 5);
                valid_v[0] = 1'b1;
                sel_v[0]   = 4'd7;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready_v[0], 0);
                    chk("bp_hold_out", out_v[0], 8'hA3);
                end
                @(posedge clk);
                #1;
                out_ready_v[0] = 1'b1;
                send(0, 7);
                drain();

                // Range handling on partial groups
                send(1, 13);
                send(1, 11);
                send(3, 13);
                send(3, 15);
                send(3, 11);
                send(3, 4);
                drain();

                // Reset with two beats in flight
                out_ready_v[0] = 1'b0;
                send(0, 1);
                send(0, 2);
                #1;
                rst = 1'b1;
                #1;
                chk("midrst_out_valid", out_valid_v[0], 0);
                chk("midrst_out", out_v[0], 0);
                chk("midrst_in_ready", in_ready_v[0], 1);
                @(negedge clk);
                @(posedge clk);
                #1;
                rst = 1'b0;
                out_ready_v = '1;
                seen = 0;
                repeat (6) begin
                    @(negedge clk);
                    if (out_valid_v[0]) seen++;
                end
                chk("no_stale_beat", seen, 0);
                chk("post_rst_in_ready", in_ready_v[0], 1);

`ifdef MUX_TREE_AUTO_SCAN_EN
                pop_log.delete();
                @(posedge clk);
                #1;
                scan_v[0] = 1'b1;
                for (int k = 0; k < 18; k++) send(0, int'($urandom_range(0, 15)));
                scan_v[0] = 1'b0;
                send(0, 9);
                scan_v[0] = 1'b1;
                send(0, 5);
                scan_v[0] = 1'b0;
                drain();
                chk("scan_count", pop_log.size(), 20);
                for (int k = 0; k < 20 && k < pop_log.size(); k++) begin
                    chk("scan_sel", pop_log[k], (k < 16) ? k : (k == 16) ? 0 : (k == 17) ? 1 :
                        (k == 18) ? 9 : 2);
                end
`endif

                // Random traffic on all lanes with random backpressure
                begin
                    logic [NL-1:0] hs;
                    for (int c = 0; c < 600; c++) begin
                        @(negedge clk);
                        hs = valid_v & in_ready_v;
                        @(posedge clk);
                        #1;
                        for (int l = 0; l < NL; l++) begin
                            if (!valid_v[l] || hs[l]) begin
                                chan[l][$urandom_range(0, 15)] = 8'($urandom);
                                valid_v[l] = ($urandom_range(0, 3) != 0);
                                sel_v[l]   = 4'($urandom_range(0, (lane_n(l) == 4) ? 3 : 15));
                                scan_v[l]  = ($urandom_range(0, 3) == 0);
                            end
                            out_ready_v[l] = ($urandom_range(0, 3) != 0);
                        end
                    end
                end
                drain();
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
